// File: rtl/apb_master.sv
// apb_master: APB initiator turning single-beat commands into APB transfers
// to the GPIO (psel 2'b01) and UART (psel 2'b10) slaves, one response each.
// Optional ACCESS-phase timeout compiled in with `define APB_MASTER_TIMEOUT_EN;
// without it ACCESS waits on pready indefinitely.
module apb_master #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_sel,
  input  logic [31:0]       cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       pAdd,
  output logic [DATA_W-1:0] pwData,
  output logic [1:0]        psel,
  output logic              pen,
  output logic              pwr,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;

  // Elaboration-time guard on the timeout limit (16-bit counter).
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        to_hit;

  // Terminal count: this ACCESS cycle is the TIMEOUT_CYCLES-th without pready.
  assign to_hit = (wait_cnt == TO_LAST);
`endif

  // Commands are only taken in IDLE and never while reset is asserted.
  assign cmd_ready = (state == IDLE) && !rst;

  // Transfer sequencer: IDLE -> SETUP -> ACCESS, with registered APB and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 2'b00;
      pen       <= 1'b0;
      pwr       <= 1'b0;
      pAdd      <= '0;
      pwData    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pAdd   <= cmd_addr;
            pwData <= cmd_write ? cmd_wdata : '0;
            pwr    <= cmd_write;
            psel   <= cmd_sel ? 2'b10 : 2'b01;
            state  <= SETUP;
          end
        end
        SETUP: begin
          pen   <= 1'b1;
          state <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle.
          if (pready) begin
            psel      <= 2'b00;
            pen       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (pwr || pslverr) ? '0 : prdata;
            state     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (to_hit) begin
            psel      <= 2'b00;
            pen       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed stimulus for apb_master, checked every
// cycle against a transaction-schedule model (setup cycle, wait count, response
// cycle), plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int TO   = 8;
  localparam int MAXC = 8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_sel;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] pAdd, pwData;
  logic [1:0]  psel;
  logic        pen, pwr;
  logic [31:0] prdata;
  logic        pready, pslverr;

  apb_master #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pAdd(pAdd), .pwData(pwData), .psel(psel), .pen(pen), .pwr(pwr),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  k;
  } cmd_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: the last accepted transfer and the cycle its SETUP occupies.
  bit   m_have;
  int   m_s;
  int   m_kx;
  bit   m_abort;
  cmd_t m;
  bit   just_rst;

  bit   pend_valid;
  cmd_t pend;
  bit   rst_req;
  int   last_acc;

  logic [1:0]  psel_log [MAXC];
  bit          pen_log  [MAXC];
  bit          rv_log   [MAXC];
  bit          rdy_log  [MAXC];
  logic [31:0] rd_log   [MAXC];
  bit          err_log  [MAXC];

  function automatic cmd_t mk(logic wr, logic sel, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, logic err, int k);
    cmd_t c;
    c.wr = wr; c.sel = sel; c.addr = addr; c.wdata = wdata;
    c.rdata = rdata; c.err = err; c.k = 8'(k);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else if (n_chk - n_pass <= 40)
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic model_reset();
    m_have = 0; m_s = 0; m_kx = 0; m_abort = 0;
    m = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    just_rst = 1;
  endtask

  // Compare DUT outputs in the current cycle with what the schedule implies.
  task automatic check_cycle();
    int          t;
    bit          in_s, in_a, erv;
    logic [1:0]  es;
    logic [31:0] erd;
    bit          eer;
    t    = cyc;
    in_s = m_have && (t == m_s);
    in_a = m_have && (t >= m_s + 1) && (t <= m_s + 1 + m_kx);
    es   = (in_s || in_a) ? (m.sel ? 2'b10 : 2'b01) : 2'b00;
    erv  = m_have && (t == m_s + 2 + m_kx);
    chk("psel", 32'(psel), 32'(es));
    chk("pen", 32'(pen), 32'(in_a));
    chk("pAdd", pAdd, m.addr);
    chk("pwr", 32'(pwr), 32'(m.wr));
    chk("pwData", pwData, m.wr ? m.wdata : 32'h0);
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    chk("cmd_ready", 32'(cmd_ready), 32'(!rst && (!m_have || t >= m_s + 2 + m_kx)));
    if (erv || just_rst) begin
      erd = (erv && !m_abort && !m.wr && !m.err) ? m.rdata : 32'h0;
      eer = erv && (m_abort || m.err);
      chk("rsp_rdata", rsp_rdata, erd);
      chk("rsp_err", 32'(rsp_err), 32'(eer));
    end
    if (t < MAXC) begin
      psel_log[t] = psel; pen_log[t] = pen; rv_log[t] = rsp_valid;
      rdy_log[t] = cmd_ready; rd_log[t] = rsp_rdata; err_log[t] = rsp_err;
    end
  endtask

  // Inputs for the rest of this cycle; the slave answers on the model's schedule.
  task automatic drive();
    int t;
    bit in_a;
    t = cyc;
    rst = rst_req;
    cmd_valid = pend_valid;
    if (pend_valid) begin
      cmd_write = pend.wr; cmd_sel = pend.sel; cmd_addr = pend.addr; cmd_wdata = pend.wdata;
    end else begin
      cmd_write = 1'($urandom); cmd_sel = 1'($urandom);
      cmd_addr = $urandom; cmd_wdata = $urandom;
    end
    in_a = m_have && (t >= m_s + 1) && (t <= m_s + 1 + m_kx);
    prdata  = $urandom;
    pslverr = 1'($urandom);
    if (in_a) pready = !m_abort && (t == m_s + 1 + int'(m.k));
    else      pready = 1'($urandom);
    if (in_a && pready) begin
      prdata = m.rdata; pslverr = m.err;
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic update();
    int t;
    t = cyc;
    just_rst = 0;
    if (rst) begin
      model_reset();
    end else if (cmd_valid && (!m_have || t >= m_s + 2 + m_kx)) begin
      m = pend; m_have = 1; m_s = t + 1; m_abort = 0; m_kx = int'(pend.k);
`ifdef APB_MASTER_TIMEOUT_EN
      if (int'(pend.k) >= TO) begin m_abort = 1; m_kx = TO - 1; end
`endif
      pend_valid = 0;
      last_acc = t;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive();
    update();
    cyc++;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic wait_accept(output int acc);
    int guard;
    guard = 0;
    while (pend_valid && guard < 300) begin step(); guard++; end
    if (pend_valid) begin
      n_chk++;
      $display("FAIL accept_wait: command not accepted within 300 cycles, expected acceptance");
      pend_valid = 0;
    end
    acc = last_acc;
  endtask

  task automatic issue(input cmd_t c, output int acc);
    pend = c; pend_valid = 1;
    wait_accept(acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, a2, pc, nrv;
    cmd_t c;
    // Reset held over three edges with a command presented.
    rst = 1'b1; rst_req = 1;
    pend = mk(1'b1, 1'b1, 32'h4, 32'hA5A5_1234, 32'h0, 1'b0, 0);
    pend_valid = 1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 1'b1;
    cmd_addr = 32'h4; cmd_wdata = 32'hA5A5_1234;
    pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;
    model_reset();
    step(); step();
    rst_req = 0; pend_valid = 0;
    step();
    chk("rst_psel", 32'(psel_log[2]), 32'h0);
    chk("rst_ready", 32'(rdy_log[1]), 32'h0);

    // UART write, zero wait.
    issue(mk(1'b1, 1'b1, 32'h4, 32'hA5A5_1234, 32'h0, 1'b0, 0), a);
    drain(4);
    chk("uw_ready_after_rst", 32'(rdy_log[3]), 32'h1);
    chk("uw_accept_cycle", 32'(a), 32'd3);
    chk("uw_psel_setup", 32'(psel_log[a+1]), 32'h2);
    chk("uw_psel_access", 32'(psel_log[a+2]), 32'h2);
    chk("uw_pen_setup", 32'(pen_log[a+1]), 32'h0);
    chk("uw_pen_access", 32'(pen_log[a+2]), 32'h1);
    chk("uw_psel_after", 32'(psel_log[a+3]), 32'h0);
    chk("uw_rsp_latency", 32'(rv_log[a+3]), 32'h1);
    chk("uw_rsp_err", 32'(err_log[a+3]), 32'h0);

    // GPIO read with four wait states.
    issue(mk(1'b0, 1'b0, 32'h10, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0, 4), a);
    drain(9);
    pc = 0;
    for (int i = a + 1; i <= a + 7; i++) if (pen_log[i]) pc++;
    chk("gr_pen_cycles", 32'(pc), 32'd5);
    chk("gr_psel", 32'(psel_log[a+1]), 32'h1);
    chk("gr_rsp_valid", 32'(rv_log[a+7]), 32'h1);
    chk("gr_rsp_rdata", rd_log[a+7], 32'hDEAD_BEEF);

    // Slave error on a read.
    issue(mk(1'b0, 1'b1, 32'h8, 32'h0, 32'h1234_5678, 1'b1, 0), a);
    drain(5);
    chk("se_rsp_valid", 32'(rv_log[a+3]), 32'h1);
    chk("se_rsp_err", 32'(err_log[a+3]), 32'h1);
    chk("se_rsp_rdata", rd_log[a+3], 32'h0);

    // Back-to-back: second accepted in the first's response cycle.
    issue(mk(1'b1, 1'b1, 32'h20, 32'hCAFE_0001, 32'h0, 1'b0, 1), a1);
    issue(mk(1'b0, 1'b0, 32'h24, 32'h0, 32'h0BAD_F00D, 1'b0, 0), a2);
    drain(6);
    chk("b2b_accept_cycle", 32'(a2 - a1), 32'd4);
    chk("b2b_rsp1", 32'(rv_log[a2]), 32'h1);
    chk("b2b_psel_before", 32'(psel_log[a2-1]), 32'h2);
    chk("b2b_psel_gap", 32'(psel_log[a2]), 32'h0);
    chk("b2b_psel_next", 32'(psel_log[a2+1]), 32'h1);
    chk("b2b_rsp2_rdata", rd_log[a2+3], 32'h0BAD_F00D);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout: pready never arrives.
    issue(mk(1'b0, 1'b0, 32'h30, 32'h0, 32'h5555_5555, 1'b0, 60), a);
    drain(13);
    chk("to_pen_last", 32'(pen_log[a+9]), 32'h1);
    chk("to_rsp_valid", 32'(rv_log[a+10]), 32'h1);
    chk("to_rsp_err", 32'(err_log[a+10]), 32'h1);
    chk("to_rsp_rdata", rd_log[a+10], 32'h0);
    chk("to_psel_after", 32'(psel_log[a+10]), 32'h0);
`endif

    // Reset in the middle of ACCESS aborts without a response.
    issue(mk(1'b1, 1'b0, 32'h40, 32'h7777_8888, 32'h0, 1'b0, 20), a);
    drain(3);
    rst_req = 1;
    step();
    rst_req = 0;
    drain(24);
    nrv = 0;
    for (int i = a + 1; i <= a + 26; i++) if (rv_log[i]) nrv++;
    chk("mr_pen_before", 32'(pen_log[a+4]), 32'h1);
    chk("mr_psel_after", 32'(psel_log[a+5]), 32'h0);
    chk("mr_pen_after", 32'(pen_log[a+5]), 32'h0);
    chk("mr_no_rsp", 32'(nrv), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      drain($urandom_range(0, 3));
`ifdef APB_MASTER_TIMEOUT_EN
      c = mk(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             1'($urandom_range(0, 3) == 0), $urandom_range(0, 11));
`else
      c = mk(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             1'($urandom_range(0, 3) == 0), $urandom_range(0, 6));
`endif
      issue(c, a);
    end
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that turns single-beat commands from the processor-side logic into APB transfers to the UART (psel = 2'b10) and GPIO (psel = 2'b01) slaves. It drives pAdd/pwData/psel/pen/pwr, waits on pready, captures prdata/pslverr, and returns one response per command. It sits between the command source and the existing APB slaves, and is the initiator end of the same bus.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase wait cycles; used only when the timeout feature is compiled in; legal range 1..65535.

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_write  in  1  1 = write, 0 = read
- cmd_sel  in  1  0 = GPIO (psel 2'b01), 1 = UART (psel 2'b10)
- cmd_addr  in  32  transfer address
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  slave error or timeout, qualified by rsp_valid
- pAdd  out  32  APB address
- pwData  out  32  APB write data
- psel  out  2  one-hot slave select
- pen  out  1  APB enable
- pwr  out  1  APB write
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error, sampled with pready

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1; psel = 0, pen = 0. On cmd_valid && cmd_ready, register cmd_addr/cmd_wdata/cmd_write/cmd_sel -> SETUP.
- SETUP (exactly one cycle): psel per cmd_sel, pen = 0, pAdd/pwData/pwr driven from registers -> ACCESS.
- ACCESS: psel held, pen = 1, all APB outputs stable. If pready = 1: capture prdata (reads only) and pslverr, -> IDLE, and pulse rsp_valid in the following cycle. If pready = 0: remain.
- Write response: rsp_rdata = 0, rsp_err = pslverr. Read response: rsp_rdata = prdata, or 0 when pslverr = 1.
- cmd_valid while not IDLE: ignored (cmd_ready = 0); no queueing.
- pwData is driven 0 for reads; pAdd/pwData/pwr hold their last value in IDLE, and psel/pen return to 0.
- Reset values: cmd_ready 0 during reset, 1 from the first cycle after; psel 0, pen 0, pwr 0, pAdd 0, pwData 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; state IDLE.
- Reset mid-transfer: psel/pen drop at the next edge and no response is emitted for the aborted command.

## Timing
- Command accepted at edge N: SETUP (psel high) during cycle N+1, ACCESS (pen high) from cycle N+2.
- pready sampled high at the end of cycle N+2+k: rsp_valid high and cmd_ready high in cycle N+3+k.
- Minimum accept-to-response latency is 3 cycles.
- Back-to-back commands: a command presented in the rsp_valid cycle is accepted, so the minimum issue rate is one transfer per 3 cycles.
- rsp_valid is registered and never lasts more than one cycle. There is no rsp_ready; the consumer must take the response in that cycle.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ACCESS and increments for each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts: psel/pen go to 0, the block moves to IDLE, and it emits rsp_valid with rsp_err = 1 and rsp_rdata = 0.
  - If pready = 1 arrives in the same cycle as the terminal count, pready wins and the transfer completes normally.
- APB_MASTER_TIMEOUT_EN undefined: no counter exists, ACCESS waits indefinitely, and TIMEOUT_CYCLES is ignored.

## Test plan
- Reset: hold rst = 1 for 3 cycles with cmd_valid = 1 -> all outputs 0 and no transfer; cmd_ready = 1 on the first cycle after release.
- UART write: cmd_sel = 1, addr 0x0000_0004, wdata 0xA5A5_1234, pready tied 1 -> psel = 2'b10 for 2 cycles, pen high 1 cycle with pwr = 1 and pwData = 0xA5A5_1234; rsp_valid 3 cycles after accept with rsp_err = 0.
- GPIO read with wait states: cmd_sel = 0, pready low 4 ACCESS cycles, then high with prdata = 0xDEAD_BEEF -> psel = 2'b01, pen high 5 cycles, APB outputs stable throughout; rsp_rdata = 0xDEAD_BEEF.
- Slave error: read with pslverr = 1 and pready = 1 -> rsp_err = 1, rsp_rdata = 0.
- Back-to-back: cmd_valid held with two commands -> the second is accepted in the rsp_valid cycle of the first; psel low for exactly one IDLE cycle between the transfers.
- Timeout (macro defined, TIMEOUT_CYCLES = 8, pready held 0) -> abort after 8 ACCESS cycles, rsp_err = 1. Reset asserted mid-ACCESS -> psel/pen 0 the next cycle and no rsp_valid.
